// File: rtl/audio_out_scheduler.sv
// ============================================================================
// audio_out_scheduler
// ----------------------------------------------------------------------------
// Shares the write side of the audio codec controller between several
// sound-effect sources. Requesting sources are granted round-robin. The
// owner's stereo samples are attenuated and streamed into the DAC FIFO one
// write at a time. Idle periods are optionally filled with silence, and the
// DAC FIFO is flushed when a stream is abandoned part-way through.
//
// Parameters
//   NUM_SRC       number of sample sources (2..8)
//   DATA_WIDTH    sample width, two's complement
//   SILENCE_FILL  1 = write zero samples while idle
//
// Ports
//   CLOCK_50                  system clock, rising edge
//   reset                     synchronous, active-high
//   src_req                   per-source level request, held until last sample
//   src_valid                 per-source sample present
//   src_last                  presented sample ends the stream
//   src_left / src_right      packed samples, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_ready                 combinational accept, transfer = valid & ready
//   src_grant                 registered one-hot owner (zero when idle)
//   atten                     master attenuation, arithmetic right shift 0..7
//   audio_out_allowed         DAC FIFO has space
//   write_audio_out           registered one-cycle write strobe
//   left/right_channel_audio_out  registered sample data
//   clear_audio_out_memory    registered one-cycle FIFO flush
//   busy                      high while streaming
// ============================================================================
module audio_out_scheduler #(
    parameter int NUM_SRC      = 4,
    parameter int DATA_WIDTH   = 24,
    parameter bit SILENCE_FILL = 1'b1
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            src_req,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC-1:0]            src_last,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_left,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_right,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic [NUM_SRC-1:0]            src_grant,
    input  logic [2:0]                    atten,
    input  logic                          audio_out_allowed,
    output logic                          write_audio_out,
    output logic [DATA_WIDTH-1:0]         left_channel_audio_out,
    output logic [DATA_WIDTH-1:0]         right_channel_audio_out,
    output logic                          clear_audio_out_memory,
    output logic                          busy
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [NUM_SRC-1:0] GRANT_ONE = NUM_SRC'(1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_SRC - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_SRC-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]        lastGrant_q, lastGrant_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   left_q, left_d;
    logic [DATA_WIDTH-1:0]   right_q, right_d;
    logic                    clear_q, clear_d;

    logic                    winnerFound;
    logic [IDX_W-1:0]        winnerIdx;
    int                      searchIdx;

    logic                    ownerReq;
    logic                    ownerValid;
    logic                    ownerLast;
    logic [DATA_WIDTH-1:0]   ownerLeft;
    logic [DATA_WIDTH-1:0]   ownerRight;
    logic signed [DATA_WIDTH-1:0] shiftLeft;
    logic signed [DATA_WIDTH-1:0] shiftRight;

    logic                    canTake;
    logic                    transfer;
    logic                    abortStream;

    // Round-robin search: walk upward from the source after the previous
    // winner, wrapping at NUM_SRC, and take the first one that is requesting.
    // The inner loop compares against the rotated position so every index
    // into src_req is a loop constant.
    always_comb begin
        winnerFound = 1'b0;
        winnerIdx   = '0;
        searchIdx   = 0;
        for (int off = 1; off <= NUM_SRC; off++) begin
            searchIdx = (int'(lastGrant_q) + off) % NUM_SRC;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!winnerFound && (i == searchIdx) && src_req[i]) begin
                    winnerFound = 1'b1;
                    winnerIdx   = IDX_W'(i);
                end
            end
        end
    end

    // Select the current owner's handshake bits and samples. The grant is
    // one-hot or zero, so an AND-OR mux is enough and yields all zeros when
    // nobody owns the output.
    always_comb begin
        ownerReq   = 1'b0;
        ownerValid = 1'b0;
        ownerLast  = 1'b0;
        ownerLeft  = '0;
        ownerRight = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q[i]) begin
                ownerReq   = src_req[i];
                ownerValid = src_valid[i];
                ownerLast  = src_last[i];
                ownerLeft  = src_left[i*DATA_WIDTH +: DATA_WIDTH];
                ownerRight = src_right[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A strobe in flight blocks the next accept, which spaces writes at
    // least two cycles apart and absorbs the one-cycle lag of the codec's
    // registered audio_out_allowed. Dropping the request also withholds
    // ready, so an abort cycle never transfers.
    assign canTake     = (state_q == STREAM) && ownerReq && audio_out_allowed && !write_q;
    assign src_ready   = canTake ? grant_q : '0;
    assign transfer    = canTake && ownerValid;
    assign abortStream = (state_q == STREAM) && !ownerReq;

    // Master attenuation is a plain sign-extending shift: no rounding and no
    // saturation, so the most negative sample shifted by 7 lands exactly on
    // -(2^(DATA_WIDTH-8)).
    assign shiftLeft  = $signed(ownerLeft) >>> atten;
    assign shiftRight = $signed(ownerRight) >>> atten;

    // Next-state logic. Data registers hold their last value unless a write
    // is being launched, so the outputs stay steady between strobes.
    // Silence fill only happens when IDLE is not about to be left and no
    // flush is in progress, so a fresh stream never queues behind a zero.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        write_d     = 1'b0;
        left_d      = left_q;
        right_d     = right_q;
        clear_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (winnerFound) begin
                    state_d     = STREAM;
                    grant_d     = GRANT_ONE << winnerIdx;
                    lastGrant_d = winnerIdx;
                end else if (SILENCE_FILL && audio_out_allowed && !write_q && !clear_q) begin
                    write_d = 1'b1;
                    left_d  = '0;
                    right_d = '0;
                end
            end

            STREAM: begin
                if (abortStream) begin
                    state_d = IDLE;
                    grant_d = '0;
                    clear_d = 1'b1;
                end else if (transfer) begin
                    write_d = 1'b1;
                    left_d  = shiftLeft;
                    right_d = shiftRight;
                    if (ownerLast) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State register. last_grant resets to the top index so source 0 is
    // favoured first. A reset mid-stream simply drops the stream; it does
    // not flush the FIFO.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            lastGrant_q <= LAST_IDX;
            write_q     <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            clear_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            write_q     <= write_d;
            left_q      <= left_d;
            right_q     <= right_d;
            clear_q     <= clear_d;
        end
    end

    assign src_grant               = grant_q;
    assign write_audio_out         = write_q;
    assign left_channel_audio_out  = left_q;
    assign right_channel_audio_out = right_q;
    assign clear_audio_out_memory  = clear_q;
    assign busy                    = (state_q == STREAM);

endmodule

// File: tb/tb_audio_out_scheduler.sv
// ============================================================================
// tb_audio_out_scheduler
// ----------------------------------------------------------------------------
// Self-checking bench for audio_out_scheduler (NUM_SRC=4, DATA_WIDTH=24,
// SILENCE_FILL=1). A table of hand-computed vectors covers a single stream,
// silence fill and attenuation; hand-written sequences cover round robin,
// abort, backpressure and reset mid-stream.
// ============================================================================
module tb_audio_out_scheduler;

    localparam int NS = 4;
    localparam int DW = 24;

    logic              CLOCK_50 = 1'b0;
    logic              reset;
    logic [NS-1:0]     src_req;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_last;
    logic [NS*DW-1:0]  src_left;
    logic [NS*DW-1:0]  src_right;
    logic [NS-1:0]     src_ready;
    logic [NS-1:0]     src_grant;
    logic [2:0]        atten;
    logic              audio_out_allowed;
    logic              write_audio_out;
    logic [DW-1:0]     left_channel_audio_out;
    logic [DW-1:0]     right_channel_audio_out;
    logic              clear_audio_out_memory;
    logic              busy;

    audio_out_scheduler #(
        .NUM_SRC      (NS),
        .DATA_WIDTH   (DW),
        .SILENCE_FILL (1'b1)
    ) dut (
        .CLOCK_50                (CLOCK_50),
        .reset                   (reset),
        .src_req                 (src_req),
        .src_valid               (src_valid),
        .src_last                (src_last),
        .src_left                (src_left),
        .src_right               (src_right),
        .src_ready               (src_ready),
        .src_grant               (src_grant),
        .atten                   (atten),
        .audio_out_allowed       (audio_out_allowed),
        .write_audio_out         (write_audio_out),
        .left_channel_audio_out  (left_channel_audio_out),
        .right_channel_audio_out (right_channel_audio_out),
        .clear_audio_out_memory  (clear_audio_out_memory),
        .busy                    (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [NS-1:0]    req;
        logic [NS-1:0]    valid;
        logic [NS-1:0]    last;
        logic [NS*DW-1:0] left;
        logic [NS*DW-1:0] right;
        logic [2:0]       atten;
        logic             allowed;
        logic [NS-1:0]    eReady;
        logic [NS-1:0]    eGrant;
        logic             eWrite;
        logic [DW-1:0]    eLeft;
        logic [DW-1:0]    eRight;
        logic             eClear;
        logic             eBusy;
    } vec_t;

    vec_t tbl [16];

    int checks = 0;
    int errors = 0;

    // Stream-driver state shared by the multi-cycle sequences
    logic [NS-1:0] reqDrv;
    logic          allowedDrv;
    int            streamLen;
    int            sampleCnt [NS];
    int            streamsDone;
    int            nWrites;
    int            xferSrc;
    logic          pendingWrite;
    logic          checkSpur;
    logic [DW-1:0] expL;
    logic [DW-1:0] expR;

    logic [NS-1:0] rrExp [4];
    logic [NS-1:0] prevGrant;
    int            nGrants;
    int            gap;
    int            doneBefore;
    int            writesBefore;
    int            lat;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [NS*DW-1:0] slot(input int s, input logic [DW-1:0] v);
        logic [NS*DW-1:0] r;
        r = '0;
        r[s*DW +: DW] = v;
        return r;
    endfunction

    function automatic vec_t mkVec(
        input logic [NS-1:0] req, input logic [NS-1:0] valid, input logic [NS-1:0] last,
        input logic [NS*DW-1:0] left, input logic [NS*DW-1:0] right,
        input logic [2:0] at, input logic allowed,
        input logic [NS-1:0] eReady, input logic [NS-1:0] eGrant, input logic eWrite,
        input logic [DW-1:0] eLeft, input logic [DW-1:0] eRight,
        input logic eClear, input logic eBusy);
        vec_t v;
        v.req = req; v.valid = valid; v.last = last;
        v.left = left; v.right = right; v.atten = at; v.allowed = allowed;
        v.eReady = eReady; v.eGrant = eGrant; v.eWrite = eWrite;
        v.eLeft = eLeft; v.eRight = eRight; v.eClear = eClear; v.eBusy = eBusy;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        src_req           = v.req;
        src_valid         = v.valid;
        src_last          = v.last;
        src_left          = v.left;
        src_right         = v.right;
        atten             = v.atten;
        audio_out_allowed = v.allowed;
    endtask

    function automatic logic [DW-1:0] sampleL(input int s, input int n);
        return DW'(32'h010000 * (s + 1) + 32'h10 * (n + 1));
    endfunction

    function automatic logic [DW-1:0] sampleR(input int s, input int n);
        return sampleL(s, n) ^ 24'h800000;
    endfunction

    task automatic driveStream();
        src_req           = reqDrv;
        src_valid         = reqDrv;
        audio_out_allowed = allowedDrv;
        atten             = 3'd0;
        src_last          = '0;
        for (int i = 0; i < NS; i++) begin
            src_last[i]             = (sampleCnt[i] == streamLen - 1);
            src_left[i*DW +: DW]    = sampleL(i, sampleCnt[i]);
            src_right[i*DW +: DW]   = sampleR(i, sampleCnt[i]);
        end
    endtask

    // One clock of the stream driver: check the write launched by the
    // previous cycle's transfer (or that no write appears), drive the
    // sources, then note which source (if any) transfers this cycle.
    task automatic streamCycle();
        logic [NS-1:0] xfer;
        @(posedge CLOCK_50);
        #1;
        if (pendingWrite) begin
            checkOutput("wrStrobe", 32'(write_audio_out), 32'd1);
            checkOutput("wrLeft", 32'(left_channel_audio_out), 32'(expL));
            checkOutput("wrRight", 32'(right_channel_audio_out), 32'(expR));
            if (write_audio_out) nWrites++;
            pendingWrite = 1'b0;
        end else if (checkSpur) begin
            checkOutput("noSpuriousWrite", 32'(write_audio_out), 32'd0);
        end
        driveStream();
        #1;
        xfer    = src_valid & src_ready;
        xferSrc = -1;
        if (xfer != '0) begin
            checkOutput("xferOneHot", $countones(xfer), 32'd1);
            for (int i = 0; i < NS; i++) if (xfer[i]) xferSrc = i;
            pendingWrite = 1'b1;
            expL = sampleL(xferSrc, sampleCnt[xferSrc]);
            expR = sampleR(xferSrc, sampleCnt[xferSrc]);
            if (sampleCnt[xferSrc] == streamLen - 1) begin
                sampleCnt[xferSrc] = 0;
                streamsDone++;
            end else begin
                sampleCnt[xferSrc]++;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        src_req = '0; src_valid = '0; src_last = '0;
        src_left = '0; src_right = '0; atten = 3'd0; audio_out_allowed = 1'b0;
        reqDrv = '0; allowedDrv = 1'b0; streamLen = 1; streamsDone = 0; nWrites = 0;
        xferSrc = -1; pendingWrite = 1'b0; checkSpur = 1'b0; expL = '0; expR = '0;
        for (int i = 0; i < NS; i++) sampleCnt[i] = 0;
        rrExp = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};

        //                req     valid   last    left                    right                   at    al     rdy     grant   wr    L          R          clr   busy
        tbl[0]  = mkVec(4'b0010, 4'b0010, 4'b0000, slot(1, 24'h000100), slot(1, 24'h000100), 3'd0, 1'b1, 4'b0000, 4'b0000, 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0);
        tbl[1]  = mkVec(4'b0010, 4'b0010, 4'b0000, slot(1, 24'h000100), slot(1, 24'h000100), 3'd0, 1'b1, 4'b0010, 4'b0010, 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b1);
        tbl[2]  = mkVec(4'b0010, 4'b0010, 4'b0000, slot(1, 24'h000200), slot(1, 24'h000200), 3'd0, 1'b1, 4'b0000, 4'b0010, 1'b1, 24'h000100, 24'h000100, 1'b0, 1'b1);
        tbl[3]  = mkVec(4'b0010, 4'b0010, 4'b0000, slot(1, 24'h000200), slot(1, 24'h000200), 3'd0, 1'b1, 4'b0010, 4'b0010, 1'b0, 24'h000100, 24'h000100, 1'b0, 1'b1);
        tbl[4]  = mkVec(4'b0010, 4'b0010, 4'b0010, slot(1, 24'h000300), slot(1, 24'h000300), 3'd0, 1'b1, 4'b0000, 4'b0010, 1'b1, 24'h000200, 24'h000200, 1'b0, 1'b1);
        tbl[5]  = mkVec(4'b0010, 4'b0010, 4'b0010, slot(1, 24'h000300), slot(1, 24'h000300), 3'd0, 1'b1, 4'b0010, 4'b0010, 1'b0, 24'h000200, 24'h000200, 1'b0, 1'b1);
        tbl[6]  = mkVec(4'b0000, 4'b0000, 4'b0000, '0, '0, 3'd0, 1'b1, 4'b0000, 4'b0000, 1'b1, 24'h000300, 24'h000300, 1'b0, 1'b0);
        tbl[7]  = mkVec(4'b0000, 4'b0000, 4'b0000, '0, '0, 3'd0, 1'b1, 4'b0000, 4'b0000, 1'b0, 24'h000300, 24'h000300, 1'b0, 1'b0);
        tbl[8]  = mkVec(4'b0000, 4'b0000, 4'b0000, '0, '0, 3'd0, 1'b0, 4'b0000, 4'b0000, 1'b1, 24'h000000, 24'h000000, 1'b0, 1'b0);
        tbl[9]  = mkVec(4'b0100, 4'b0100, 4'b0100, slot(2, 24'hFF8000), slot(2, 24'h7FFFFF), 3'd3, 1'b1, 4'b0000, 4'b0000, 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0);
        tbl[10] = mkVec(4'b0100, 4'b0100, 4'b0100, slot(2, 24'hFF8000), slot(2, 24'h7FFFFF), 3'd3, 1'b1, 4'b0100, 4'b0100, 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b1);
        tbl[11] = mkVec(4'b0000, 4'b0000, 4'b0000, '0, '0, 3'd0, 1'b0, 4'b0000, 4'b0000, 1'b1, 24'hFFF000, 24'h0FFFFF, 1'b0, 1'b0);
        tbl[12] = mkVec(4'b1000, 4'b1000, 4'b1000, slot(3, 24'h7FFFFF), slot(3, 24'h800000), 3'd7, 1'b1, 4'b0000, 4'b0000, 1'b0, 24'hFFF000, 24'h0FFFFF, 1'b0, 1'b0);
        tbl[13] = mkVec(4'b1000, 4'b1000, 4'b1000, slot(3, 24'h7FFFFF), slot(3, 24'h800000), 3'd7, 1'b1, 4'b1000, 4'b1000, 1'b0, 24'hFFF000, 24'h0FFFFF, 1'b0, 1'b1);
        tbl[14] = mkVec(4'b0000, 4'b0000, 4'b0000, '0, '0, 3'd0, 1'b0, 4'b0000, 4'b0000, 1'b1, 24'h00FFFF, 24'hFF0000, 1'b0, 1'b0);
        tbl[15] = mkVec(4'b0000, 4'b0000, 4'b0000, '0, '0, 3'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 24'h00FFFF, 24'hFF0000, 1'b0, 1'b0);

        repeat (2) @(posedge CLOCK_50);
        #1;
        reset = 1'b0;

        // Table: single stream from source 1, silence fill, attenuation
        for (int r = 0; r < 16; r++) begin
            applyStimulus(tbl[r]);
            #1;
            checkOutput($sformatf("r%0d_ready", r), 32'(src_ready), 32'(tbl[r].eReady));
            checkOutput($sformatf("r%0d_grant", r), 32'(src_grant), 32'(tbl[r].eGrant));
            checkOutput($sformatf("r%0d_write", r), 32'(write_audio_out), 32'(tbl[r].eWrite));
            checkOutput($sformatf("r%0d_left", r), 32'(left_channel_audio_out), 32'(tbl[r].eLeft));
            checkOutput($sformatf("r%0d_right", r), 32'(right_channel_audio_out), 32'(tbl[r].eRight));
            checkOutput($sformatf("r%0d_clear", r), 32'(clear_audio_out_memory), 32'(tbl[r].eClear));
            checkOutput($sformatf("r%0d_busy", r), 32'(busy), 32'(tbl[r].eBusy));
            @(posedge CLOCK_50);
            #1;
        end

        // Round robin: sources 0 and 2, 2-sample streams, requests held
        reqDrv = 4'b0101; allowedDrv = 1'b1; streamLen = 2; streamsDone = 0;
        checkSpur = 1'b1; prevGrant = '0; nGrants = 0; gap = 0;
        for (int c = 0; c < 100 && streamsDone < 4; c++) begin
            streamCycle();
            if (src_grant != '0 && prevGrant == '0) begin
                if (nGrants < 4) checkOutput($sformatf("rrGrant%0d", nGrants), 32'(src_grant), 32'(rrExp[nGrants]));
                if (nGrants > 0) checkOutput("rrIdleGap", gap, 32'd1);
                nGrants++;
                gap = 0;
            end else if (src_grant == '0 && nGrants > 0) begin
                gap++;
            end
            prevGrant = src_grant;
        end
        checkOutput("rrStreamsDone", streamsDone, 32'd4);
        checkOutput("rrGrantCount", nGrants, 32'd4);
        reqDrv = '0; allowedDrv = 1'b0;
        streamCycle();
        streamCycle();

        // Abort: source 3 wins over 0, drops its request after one sample
        reqDrv = 4'b1001; allowedDrv = 1'b1; streamLen = 4;
        streamCycle();
        streamCycle();
        checkOutput("abortGrant3", 32'(src_grant), 32'(4'b1000));
        for (int c = 0; c < 20 && sampleCnt[3] == 0; c++) streamCycle();
        checkOutput("abortOneSample", sampleCnt[3], 32'd1);
        reqDrv = 4'b0001; sampleCnt[3] = 0;
        streamCycle();
        checkOutput("abortReadyLow", 32'(src_ready), 32'd0);
        checkOutput("abortClearNotYet", 32'(clear_audio_out_memory), 32'd0);
        streamCycle();
        checkOutput("abortClear", 32'(clear_audio_out_memory), 32'd1);
        checkOutput("abortGrantZero", 32'(src_grant), 32'd0);
        checkOutput("abortBusyLow", 32'(busy), 32'd0);
        streamCycle();
        checkOutput("abortClearOnce", 32'(clear_audio_out_memory), 32'd0);
        checkOutput("abortNextGrant0", 32'(src_grant), 32'(4'b0001));
        checkOutput("abortBusyHigh", 32'(busy), 32'd1);
        doneBefore = streamsDone; writesBefore = nWrites;
        for (int c = 0; c < 40 && streamsDone == doneBefore; c++) streamCycle();
        reqDrv = '0; allowedDrv = 1'b0;
        streamCycle();
        streamCycle();
        checkOutput("abortSrc0Writes", nWrites - writesBefore, 32'd4);

        // Backpressure: source 1, allowed low for 10 cycles after 2 samples
        reqDrv = 4'b0010; allowedDrv = 1'b1; streamLen = 4;
        doneBefore = streamsDone; writesBefore = nWrites;
        streamCycle();
        streamCycle();
        checkOutput("bpGrant1", 32'(src_grant), 32'(4'b0010));
        for (int c = 0; c < 20 && sampleCnt[1] < 2; c++) streamCycle();
        checkOutput("bpTwoSent", sampleCnt[1], 32'd2);
        allowedDrv = 1'b0;
        for (int k = 0; k < 10; k++) begin
            streamCycle();
            checkOutput($sformatf("bpReady%0d", k), 32'(src_ready), 32'd0);
        end
        allowedDrv = 1'b1;
        lat = 0;
        do begin
            streamCycle();
            lat++;
        end while (xferSrc < 0 && lat < 4);
        checkOutput("bpResumeLatency", lat, 32'd1);
        for (int c = 0; c < 40 && streamsDone == doneBefore; c++) streamCycle();
        reqDrv = '0; allowedDrv = 1'b0;
        streamCycle();
        streamCycle();
        checkOutput("bpSrc1Writes", nWrites - writesBefore, 32'd4);

        // Reset mid-stream, then silence fill every second cycle
        reqDrv = 4'b0100; allowedDrv = 1'b1; streamLen = 4;
        streamCycle();
        streamCycle();
        checkOutput("rstGrant2", 32'(src_grant), 32'(4'b0100));
        reqDrv = '0; allowedDrv = 1'b0;
        streamCycle();
        reset = 1'b1;
        checkSpur = 1'b0;
        sampleCnt[2] = 0;
        src_req = '0; src_valid = '0; src_last = '0;
        src_left = '0; src_right = '0; atten = 3'd0; audio_out_allowed = 1'b0;
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        checkOutput("rstGrant", 32'(src_grant), 32'd0);
        checkOutput("rstWrite", 32'(write_audio_out), 32'd0);
        checkOutput("rstLeft", 32'(left_channel_audio_out), 32'd0);
        checkOutput("rstRight", 32'(right_channel_audio_out), 32'd0);
        checkOutput("rstClear", 32'(clear_audio_out_memory), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstReady", 32'(src_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge CLOCK_50);
            #1;
            checkOutput("rstQuietWrite", 32'(write_audio_out), 32'd0);
            checkOutput("rstQuietClear", 32'(clear_audio_out_memory), 32'd0);
            checkOutput("rstQuietBusy", 32'(busy), 32'd0);
        end
        audio_out_allowed = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge CLOCK_50);
            #1;
            checkOutput($sformatf("silWrite%0d", k), 32'(write_audio_out), (k % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("silLeft", 32'(left_channel_audio_out), 32'd0);
            checkOutput("silRight", 32'(right_channel_audio_out), 32'd0);
            checkOutput("silBusy", 32'(busy), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
